// File: rtl/toggle_sync_pkg.sv
// Shared defaults and helpers for the toggle-synchroniser receiver.
package toggle_sync_pkg;

  localparam int CH_DEFAULT          = 4;
  localparam int SYNC_STAGES_DEFAULT = 2;
  localparam int CNT_W_DEFAULT       = 4;

  // Width of a channel index; never narrower than one bit.
  function automatic int idx_width(input int n);
    return (n <= 1) ? 1 : $clog2(n);
  endfunction

  // (base + step) mod n, for base < n and step < n.
  function automatic int rr_next(input int base, input int step, input int n);
    int s;
    s = base + step;
    return (s >= n) ? s - n : s;
  endfunction

endpackage

// File: rtl/toggle_sync_ch.sv
// One toggle channel: synchroniser chain, history flop, edge detect,
// saturating pending-event counter and sticky overflow flag.
module toggle_sync_ch
  import toggle_sync_pkg::*;
#(
  parameter int SYNC_STAGES = SYNC_STAGES_DEFAULT,
  parameter int CNT_W       = CNT_W_DEFAULT
) (
  input  logic clk,
  input  logic rstn,
  input  logic tog,
  input  logic armed,
  input  logic take,
  input  logic clr_ovf,
  output logic pulse,
  output logic pend_nz,
  output logic ovf
);

  logic [SYNC_STAGES-1:0] sync_q;
  logic                   hist_q;
  logic [CNT_W-1:0]       pend_q;
  logic                   pend_full;

  // Synchroniser chain; the history flop always follows the last stage,
  // so during arming it simply soaks up whatever level was present at release.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      sync_q <= '0;
      hist_q <= 1'b0;
    end else begin
      // NOTE: non-blocking assignments make every stage sample the previous
      // stage's old value; blocking here would collapse the chain to one flop.
      sync_q <= {sync_q[SYNC_STAGES-2:0], tog};
      hist_q <= sync_q[SYNC_STAGES-1];
    end
  end

  assign pulse     = armed & (sync_q[SYNC_STAGES-1] ^ hist_q);
  assign pend_full = &pend_q;
  assign pend_nz   = |pend_q;

  // Pending counter: +1 per event, -1 per grant, unchanged when both coincide;
  // an event arriving at a full counter is dropped and flagged in ovf.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      pend_q <= '0;
      ovf    <= 1'b0;
    end else begin
      if (pulse && !take) begin
        if (!pend_full) pend_q <= pend_q + CNT_W'(1);
      end else if (take && !pulse) begin
        pend_q <= pend_q - CNT_W'(1);
      end
      if (pulse && !take && pend_full) ovf <= 1'b1;
      else if (clr_ovf)                ovf <= 1'b0;
    end
  end

endmodule

// File: rtl/toggle_sync_rx.sv
// Multi-channel toggle receiver: CH synchronised toggle channels feeding a
// round-robin event queue with a valid/ready output register.
module toggle_sync_rx
  import toggle_sync_pkg::*;
#(
  parameter  int CH          = CH_DEFAULT,
  parameter  int SYNC_STAGES = SYNC_STAGES_DEFAULT,
  parameter  int CNT_W       = CNT_W_DEFAULT,
  localparam int IW          = idx_width(CH)
) (
  input  logic          clk,
  input  logic          rstn,
  input  logic [CH-1:0] tog_in,
  output logic [CH-1:0] pulse_out,
  output logic          evt_valid,
  output logic [IW-1:0] evt_ch,
  input  logic          evt_ready,
  output logic [CH-1:0] ovf,
  input  logic [CH-1:0] clr_ovf
);

  localparam int ARM_EDGES = SYNC_STAGES + 1;
  localparam int AW        = $clog2(ARM_EDGES + 1);

  logic [AW-1:0] arm_cnt_q;
  logic          armed;
  logic [CH-1:0] pend_nz;
  logic [CH-1:0] take;
  logic [IW-1:0] rr_ptr_q;
  logic [IW-1:0] sel;
  logic [IW-1:0] cand;
  logic          found;
  logic          load;

  // Arming counter: events are ignored until the pipeline has flushed the
  // levels that were present when reset was released.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn)       arm_cnt_q <= '0;
    else if (!armed) arm_cnt_q <= arm_cnt_q + AW'(1);
  end

  assign armed = (arm_cnt_q == AW'(ARM_EDGES));

  for (genvar i = 0; i < CH; i++) begin : g_ch
    assign take[i] = load && found && (sel == IW'(i));

    toggle_sync_ch #(
      .SYNC_STAGES(SYNC_STAGES),
      .CNT_W      (CNT_W)
    ) u_ch (
      .clk    (clk),
      .rstn   (rstn),
      .tog    (tog_in[i]),
      .armed  (armed),
      .take   (take[i]),
      .clr_ovf(clr_ovf[i]),
      .pulse  (pulse_out[i]),
      .pend_nz(pend_nz[i]),
      .ovf    (ovf[i])
    );
  end

  assign load = !evt_valid || evt_ready;

  // Round-robin search starting at rr_ptr; scanning from the far end lets the
  // nearest pending channel win without an early exit.
  always_comb begin
    // NOTE: every variable gets a default before the loop so no path leaves
    // it unassigned, which would otherwise infer a latch.
    found = 1'b0;
    sel   = '0;
    cand  = '0;
    for (int k = CH - 1; k >= 0; k--) begin
      cand = IW'(rr_next(int'(rr_ptr_q), k, CH));
      if (pend_nz[cand]) begin
        found = 1'b1;
        sel   = cand;
      end
    end
  end

  // Output register: refills whenever empty or accepted, holds under stall.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      evt_valid <= 1'b0;
      evt_ch    <= '0;
      rr_ptr_q  <= '0;
    end else if (load) begin
      evt_valid <= found;
      if (found) begin
        evt_ch   <= sel;
        rr_ptr_q <= IW'(rr_next(int'(sel), 1, CH));
      end
    end
  end

endmodule

// File: doc/toggle_sync_rx.md
TOGGLE_SYNC_RX -- requirements
Module: toggle_sync_rx

Interface
REQ-001 Parameter CH, 4, number of independent toggle channels (1..16).
REQ-002 Parameter SYNC_STAGES, 2, synchroniser flops per channel (minimum 2).
REQ-003 Parameter CNT_W, 4, width of each per-channel pending-event counter (minimum 1).
REQ-004 The block has one clock and an asynchronous, active-low reset; port names are clk and rstn.
REQ-005 clk  input  1  receiving-domain clock; all state on rising edge.
REQ-006 rstn  input  1  asynchronous active-low reset.
REQ-007 tog_in  input  CH  per-channel toggle level from a foreign domain; each level change is one event.
REQ-008 pulse_out  output  CH  one-cycle event strobe per channel.
REQ-009 evt_valid  output  1  queued event available.
REQ-010 evt_ch  output  clog2(CH) (min 1)  channel index of the presented event.
REQ-011 evt_ready  input  1  consumer accepts the presented event.
REQ-012 ovf  output  CH  sticky per-channel pending-counter overflow flag.
REQ-013 clr_ovf  input  CH  per-channel synchronous clear of ovf.

Function
REQ-014 Each tog_in bit SHALL pass through SYNC_STAGES flops, then one history flop; an event is when the last sync stage differs from the history flop.
REQ-015 pulse_out[i] SHALL be the XOR of the last sync stage and the history flop, high exactly one cycle per level change, beginning SYNC_STAGES rising edges after the first edge that samples the new level.
REQ-016 Arming: for the first SYNC_STAGES+1 rising edges after rstn deassertion, the history flop SHALL load the last sync stage while pulse_out and counter increments are suppressed; a tog_in already high at release produces no event.
REQ-017 pend[i] (CNT_W bits) SHALL increment at the edge ending a pulse_out[i] cycle and decrement at the edge where channel i is loaded into the output register; both on the same edge leave it unchanged.
REQ-018 Increment with pend[i] at all-ones and no simultaneous load: pend[i] SHALL hold and ovf[i] SHALL set; the event is lost.
REQ-019 ovf[i] SHALL clear on clr_ovf[i]; a set and a clear on the same edge leave ovf[i] set.
REQ-020 Output register (evt_valid, evt_ch) SHALL load when evt_valid is 0 or evt_ready is 1; the loaded channel is the first i with pend[i] != 0, searching rr_ptr, rr_ptr+1, ... modulo CH; evt_valid becomes 0 if none.
REQ-021 On each load of channel c, rr_ptr SHALL become (c+1) mod CH; with no load, rr_ptr holds.
REQ-022 While evt_valid=1 and evt_ready=0, evt_valid and evt_ch SHALL remain stable.
REQ-023 Best-case latency: pulse_out cycle t, pend visible t+1, evt_valid high t+2.
REQ-024 evt_ready while evt_valid=0 SHALL have no effect.
REQ-025 Back-to-back acceptance SHALL sustain one event per cycle while any pend is nonzero.

Reset
REQ-026 rstn low SHALL asynchronously clear all sync, history, pend, ovf, rr_ptr, evt_valid, evt_ch and the arming counter; pulse_out SHALL read 0.
REQ-027 Reset asserted mid-operation SHALL discard all pending and presented events; arming restarts after release.

Structure
REQ-028 Package toggle_sync_pkg SHALL hold default parameter values and the clog2-based index-width constant function.
REQ-029 Sub-module toggle_sync_ch SHALL implement one channel (sync chain, history flop, edge detect, pending counter, ovf); top instantiates CH copies plus arming counter and round-robin output stage.

Verification
REQ-030 CH=4, SYNC_STAGES=2: tog_in[0] 0->1 after arming -> pulse_out[0] high exactly one cycle, 2 edges after sampling; evt_valid high 2 cycles later with evt_ch=0.
REQ-031 tog_in=4'b1111 held through reset release -> no pulse_out, pend all 0, evt_valid stays 0.
REQ-032 evt_ready=0, channels 1 and 3 toggle once -> evt_ch=1 held stable; then evt_ready=1 -> accept 1, then 3, then evt_valid=0.
REQ-033 CNT_W=2, evt_ready=0, channel 2 toggles 5 times -> one event in output register, pend[2]=3, ovf[2]=1; clr_ovf[2] -> ovf[2]=0.
REQ-034 All 4 channels pending, evt_ready=1 constantly -> grant order 0,1,2,3 in consecutive cycles; pulse and load on the same channel and edge -> pend unchanged.
REQ-035 rstn pulsed low with pend nonzero and evt_valid=1 -> all outputs 0 immediately; no events after release until new toggles.
